// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the writeback arbiter: datapath width,
// register-index width and requester identifiers.
`timescale 1ns/1ps
package wb_arbiter_pkg;

    localparam int CORE_XLEN = 32;
    localparam int REG_W     = 5;

    // Requester identity, also used to remember who won the last conflict.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/wb_arbiter.sv
// Two-requester register-file writeback arbiter (ALU and load unit).
// Round-robin on conflicts, one registered write stage, forwarding-hit
// detection against the pending write and a saturating conflict counter.
`timescale 1ns/1ps
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN  = CORE_XLEN,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             alu_valid,
    input  logic [REG_W-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    output logic             alu_ready,

    input  logic             lsu_valid,
    input  logic [REG_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]  lsu_data,
    output logic             lsu_ready,

    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,

    output logic             write_reg,
    output logic [REG_W-1:0] target_reg,
    output logic [XLEN-1:0]  write_rd_data,
    output logic             fwd_rs1_hit,
    output logic             fwd_rs2_hit,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    req_id_e            last_winner_q, last_winner_d;
    logic               write_reg_q, write_reg_d;
    logic [REG_W-1:0]   target_q, target_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               conflict;
    logic               grant_any;
    logic [REG_W-1:0]   grant_rd;
    logic [XLEN-1:0]    grant_data;

    // Grant decision: purely from the valids and the last conflict winner;
    // nothing is accepted while reset is asserted.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        conflict  = alu_valid & lsu_valid;
        if (!rst) begin
            if (conflict) begin
                if (last_winner_q == REQ_LSU) begin
                    alu_ready = 1'b1;
                end else begin
                    lsu_ready = 1'b1;
                end
            end else if (alu_valid) begin
                alu_ready = 1'b1;
            end else if (lsu_valid) begin
                lsu_ready = 1'b1;
            end
        end
    end

    assign grant_any  = alu_ready | lsu_ready;
    assign grant_rd   = lsu_ready ? lsu_rd   : alu_rd;
    assign grant_data = lsu_ready ? lsu_data : alu_data;

    // Next state of the write stage, round-robin pointer and conflict counter.
    // A write to x0 is accepted but never raises the write enable.
    always_comb begin
        write_reg_d   = 1'b0;
        target_d      = target_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        last_winner_d = last_winner_q;
        if (grant_any) begin
            write_reg_d = (grant_rd != '0);
            target_d    = grant_rd;
            data_d      = grant_data;
        end
        if (conflict) begin
            cnt_d         = sat_inc(cnt_q);
            last_winner_d = lsu_ready ? REQ_LSU : REQ_ALU;
        end
    end

    // State registers; reset makes the ALU the winner of the first conflict
    // and drops any write that was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg_q   <= 1'b0;
            target_q      <= '0;
            data_q        <= '0;
            cnt_q         <= '0;
            last_winner_q <= REQ_LSU;
        end else begin
            write_reg_q   <= write_reg_d;
            target_q      <= target_d;
            data_q        <= data_d;
            cnt_q         <= cnt_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign write_reg     = write_reg_q;
    assign target_reg    = target_q;
    assign write_rd_data = data_q;
    assign conflict_cnt  = cnt_q;

    // x0 is hard-wired, so a pending write to it never forwards.
    assign fwd_rs1_hit = write_reg_q && (target_q != '0) && (rs1 == target_q);
    assign fwd_rs2_hit = write_reg_q && (target_q != '0) && (rs2 == target_q);

endmodule

// File: tb/tb_wb_arbiter.sv
`timescale 1ns/1ps
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic [4:0]  alu_rd, lsu_rd, rs1, rs2;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready;
    logic        write_reg, fwd_rs1_hit, fwd_rs2_hit;
    logic [4:0]  target_reg;
    logic [31:0] write_rd_data;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rs1(rs1), .rs2(rs2),
        .write_reg(write_reg), .target_reg(target_reg), .write_rd_data(write_rd_data),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit), .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        av; logic [4:0] ard; logic [31:0] ad;
        logic        lv; logic [4:0] lrd; logic [31:0] ld;
        logic [4:0]  r1; logic [4:0] r2;
        logic        e_ar; logic e_lr;
        logic        e_wr; logic chk_wd; logic [4:0] e_tgt; logic [31:0] e_dat;
        logic        e_h1; logic e_h2;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[15];

    // Reference model state (random phase)
    int          m_last;   // 0 = ALU won last conflict, 1 = LSU
    logic        m_wr;
    logic [4:0]  m_tgt;
    logic [31:0] m_dat;
    int          m_cnt;

    task automatic reset_dut();
        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        rs1 = '0; rs2 = '0;

        //            rst av ard ad         lv lrd ld         r1 r2 ar lr wr cw tgt dat        h1 h2 cnt
        vecs[0]  = '{1, 1, 5, 32'h1234,  0, 0, 32'h0,     0, 0, 0, 0, 0, 1, 0, 32'h0,     0, 0, 0};
        vecs[1]  = '{0, 1, 5, 32'h1234,  0, 0, 32'h0,     5, 0, 1, 0, 1, 1, 5, 32'h1234,  1, 0, 0};
        vecs[2]  = '{0, 1, 3, 32'h33,    1, 4, 32'h44,    3, 4, 1, 0, 1, 1, 3, 32'h33,    1, 0, 1};
        vecs[3]  = '{0, 0, 3, 32'h33,    1, 4, 32'h44,    3, 4, 0, 1, 1, 1, 4, 32'h44,    0, 1, 1};
        vecs[4]  = '{0, 0, 0, 32'h0,     0, 0, 32'h0,     4, 4, 0, 0, 0, 1, 4, 32'h44,    0, 0, 1};
        vecs[5]  = '{0, 1, 8, 32'h88,    1, 6, 32'h66,    0, 0, 0, 1, 1, 1, 6, 32'h66,    0, 0, 2};
        vecs[6]  = '{0, 1, 8, 32'h88,    1, 9, 32'h99,    8, 0, 1, 0, 1, 1, 8, 32'h88,    1, 0, 3};
        vecs[7]  = '{0, 0, 0, 32'h0,     1, 9, 32'h99,    0, 9, 0, 1, 1, 1, 9, 32'h99,    0, 1, 3};
        vecs[8]  = '{0, 0, 0, 32'h0,     1, 0, 32'hFFFF,  0, 0, 0, 1, 0, 0, 0, 32'h0,     0, 0, 3};
        vecs[9]  = '{0, 1, 7, 32'h77,    0, 0, 32'h0,     7, 0, 1, 0, 1, 1, 7, 32'h77,    1, 0, 3};
        vecs[10] = '{0, 0, 0, 32'h0,     0, 0, 32'h0,     7, 7, 0, 0, 0, 1, 7, 32'h77,    0, 0, 3};
        vecs[11] = '{0, 1, 2, 32'h22,    0, 0, 32'h0,     0, 2, 1, 0, 1, 1, 2, 32'h22,    0, 1, 3};
        vecs[12] = '{1, 1, 1, 32'h11,    1, 10, 32'hAA,   0, 0, 0, 0, 0, 1, 0, 32'h0,     0, 0, 0};
        vecs[13] = '{0, 1, 1, 32'h11,    1, 10, 32'hAA,   1, 0, 1, 0, 1, 1, 1, 32'h11,    1, 0, 1};
        vecs[14] = '{0, 0, 0, 32'h0,     1, 10, 32'hAA,   0, 10, 0, 1, 1, 1, 10, 32'hAA,  0, 1, 1};

        @(posedge clk); @(posedge clk); #1;
        chk("reset_write_reg", {31'b0, write_reg}, 32'h0);
        chk("reset_cnt", {16'b0, conflict_cnt}, 32'h0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
            rs1 = vecs[i].r1; rs2 = vecs[i].r2;
            #3;
            chk($sformatf("v%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].e_ar});
            chk($sformatf("v%0d_lsu_ready", i), {31'b0, lsu_ready}, {31'b0, vecs[i].e_lr});
            @(posedge clk); #1;
            chk($sformatf("v%0d_write_reg", i), {31'b0, write_reg}, {31'b0, vecs[i].e_wr});
            if (vecs[i].chk_wd) begin
                chk($sformatf("v%0d_target_reg", i), {27'b0, target_reg}, {27'b0, vecs[i].e_tgt});
                chk($sformatf("v%0d_wdata", i), write_rd_data, vecs[i].e_dat);
            end
            chk($sformatf("v%0d_fwd1", i), {31'b0, fwd_rs1_hit}, {31'b0, vecs[i].e_h1});
            chk($sformatf("v%0d_fwd2", i), {31'b0, fwd_rs2_hit}, {31'b0, vecs[i].e_h2});
            chk($sformatf("v%0d_cnt", i), {16'b0, conflict_cnt}, {16'b0, vecs[i].e_cnt});
        end

        // ---------------- continuous conflict alternation ----------------
        reset_dut();
        begin
            logic [4:0] ard, lrd;
            ard = 5'd11; lrd = 5'd21;
            for (int k = 0; k < 4; k++) begin
                alu_valid = 1'b1; alu_rd = ard; alu_data = 32'h100 + k;
                lsu_valid = 1'b1; lsu_rd = lrd; lsu_data = 32'h200 + k;
                #3;
                chk($sformatf("alt%0d_alu_ready", k), {31'b0, alu_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
                chk($sformatf("alt%0d_lsu_ready", k), {31'b0, lsu_ready}, (k % 2 == 0) ? 32'h0 : 32'h1);
                @(posedge clk); #1;
                chk($sformatf("alt%0d_target", k), {27'b0, target_reg},
                    (k % 2 == 0) ? {27'b0, ard} : {27'b0, lrd});
                if (k % 2 == 0) ard = ard + 5'd1; else lrd = lrd + 5'd1;
            end
            chk("alt_cnt", {16'b0, conflict_cnt}, 32'd4);
            alu_valid = 1'b0; lsu_valid = 1'b0;
        end

        // ---------------- counter saturation ----------------
        reset_dut();
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd1; lsu_rd = 5'd2;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", {16'b0, conflict_cnt}, 32'hFFFE);
        @(posedge clk); #1;
        chk("sat_ffff", {16'b0, conflict_cnt}, 32'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_hold", {16'b0, conflict_cnt}, 32'hFFFF);
        alu_valid = 1'b0; lsu_valid = 1'b0;

        // ---------------- randomized vs. reference model ----------------
        reset_dut();
        m_last = 1; m_wr = 1'b0; m_tgt = '0; m_dat = '0; m_cnt = 0;
        begin
            logic ap, lp, rv, ea, el;
            int   aw, lw;
            ap = 1'b0; lp = 1'b0; aw = 0; lw = 0;
            for (int n = 0; n < 3000; n++) begin
                if (!ap && ($urandom_range(0, 2) != 0)) begin
                    ap = 1'b1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
                end
                if (!lp && ($urandom_range(0, 2) != 0)) begin
                    lp = 1'b1; lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
                end
                rv = ($urandom_range(0, 49) == 0);
                rst = rv; alu_valid = ap; lsu_valid = lp;
                rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));

                // who should be accepted this cycle
                ea = 1'b0; el = 1'b0;
                if (!rv) begin
                    if (ap && lp) begin
                        if (m_last == 1) ea = 1'b1; else el = 1'b1;
                    end else begin
                        ea = ap; el = lp;
                    end
                end
                #3;
                chk("rnd_alu_ready", {31'b0, alu_ready}, {31'b0, ea});
                chk("rnd_lsu_ready", {31'b0, lsu_ready}, {31'b0, el});

                if (!rv && ap && !ea) aw++; else aw = 0;
                if (!rv && lp && !el) lw++; else lw = 0;
                if (aw > 0) chk("rnd_alu_wait", (aw <= 1) ? 32'h1 : 32'h0, 32'h1);
                if (lw > 0) chk("rnd_lsu_wait", (lw <= 1) ? 32'h1 : 32'h0, 32'h1);

                if (rv) begin
                    m_last = 1; m_wr = 1'b0; m_tgt = '0; m_dat = '0; m_cnt = 0;
                end else begin
                    if (ea || el) begin
                        m_tgt = ea ? alu_rd : lsu_rd;
                        m_dat = ea ? alu_data : lsu_data;
                        m_wr  = (m_tgt != 5'd0);
                    end else begin
                        m_wr = 1'b0;
                    end
                    if (ap && lp) begin
                        m_cnt  = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
                        m_last = el ? 1 : 0;
                    end
                end

                @(posedge clk); #1;
                if (ea) ap = 1'b0;
                if (el) lp = 1'b0;
                chk("rnd_write_reg", {31'b0, write_reg}, {31'b0, m_wr});
                chk("rnd_target", {27'b0, target_reg}, {27'b0, m_tgt});
                chk("rnd_wdata", write_rd_data, m_dat);
                chk("rnd_fwd1", {31'b0, fwd_rs1_hit}, (m_wr && m_tgt != 0 && rs1 == m_tgt) ? 32'h1 : 32'h0);
                chk("rnd_fwd2", {31'b0, fwd_rs2_hit}, (m_wr && m_tgt != 0 && rs2 == m_tgt) ? 32'h1 : 32'h0);
                chk("rnd_cnt", {16'b0, conflict_cnt}, m_cnt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter CNT_W, default 16, conflict-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-006 SHALL have port alu_rd  input  5  ALU destination register.
REQ-007 SHALL have port alu_data  input  XLEN  ALU result.
REQ-008 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port lsu_valid  input  1  load-unit writeback request.
REQ-010 SHALL have port lsu_rd  input  5  load destination register.
REQ-011 SHALL have port lsu_data  input  XLEN  load result.
REQ-012 SHALL have port lsu_ready  output  1  LSU request accepted this cycle.
REQ-013 SHALL have port rs1  input  5  decode-stage source 1 index for forwarding check.
REQ-014 SHALL have port rs2  input  5  decode-stage source 2 index for forwarding check.
REQ-015 SHALL have port write_reg  output  1  register-file write enable (registered).
REQ-016 SHALL have port target_reg  output  5  register-file write index (registered).
REQ-017 SHALL have port write_rd_data  output  XLEN  register-file write data (registered).
REQ-018 SHALL have port fwd_rs1_hit  output  1  rs1 matches the pending write.
REQ-019 SHALL have port fwd_rs2_hit  output  1  rs2 matches the pending write.
REQ-020 SHALL have port conflict_cnt  output  CNT_W  count of cycles both requesters were valid.

Function
REQ-021 SHALL grant at most one requester per cycle; ready is combinational from the valids and the priority state, with no dependence on the ready outputs themselves.
REQ-022 SHALL grant the sole valid requester when exactly one is valid.
REQ-023 SHALL, when both are valid, grant the requester not granted on the most recent conflict cycle (round-robin); last_conflict_winner updates only on conflict cycles.
REQ-024 SHALL hold the losing request unaccepted; the requester keeps valid, rd and data stable until ready; the loser therefore waits at most 1 cycle.
REQ-025 SHALL register the granted rd/data into the write stage on the edge ending the grant cycle; write_reg asserts exactly 1 cycle after acceptance, for 1 cycle.
REQ-026 SHALL accept a request with rd = 0 (ready = 1) but SHALL NOT assert write_reg for it.
REQ-027 SHALL deassert write_reg in any cycle following a cycle with no grant; target_reg/write_rd_data then hold their previous values.
REQ-028 SHALL assert fwd_rsN_hit when write_reg = 1, target_reg != 0 and rsN == target_reg; rsN = 0 never hits.
REQ-029 SHALL increment conflict_cnt on every cycle with alu_valid and lsu_valid both high, saturating at all-ones.
REQ-030 SHALL support back-to-back grants every cycle with no bubble.

Reset
REQ-031 SHALL, while rst is high at a clock edge, clear write_reg, target_reg, write_rd_data and conflict_cnt to 0 and set last_conflict_winner to LSU, so the ALU wins the first conflict.
REQ-032 SHALL drive alu_ready = lsu_ready = 0 combinationally while rst is high; requests presented during reset are not accepted, and an in-flight write stage is discarded.

Structure
REQ-033 SHALL take XLEN, register-index width (5) and the requester encoding (ALU = 0, LSU = 1) from the shared core package.
REQ-034 SHALL be a single module without sub-modules; the saturating counter is inline logic.

Verification
REQ-035 SHALL cover: alu_valid = 1, alu_rd = 5, alu_data = 0x1234 alone -> alu_ready = 1 same cycle; next cycle write_reg = 1, target_reg = 5, write_rd_data = 0x1234.
REQ-036 SHALL cover: first conflict after reset (ALU rd = 3, LSU rd = 4) -> ALU granted, then LSU the next cycle; writes to 3 then 4 on consecutive cycles; conflict_cnt = 1.
REQ-037 SHALL cover: both valid continuously for 4 cycles with fresh requests each grant -> grants alternate ALU, LSU, ALU, LSU; conflict_cnt = 4.
REQ-038 SHALL cover: LSU rd = 0, data = 0xFFFF -> lsu_ready = 1, write_reg stays 0 the following cycle.
REQ-039 SHALL cover: pending write to rd = 7 with rs1 = 7, rs2 = 0 -> fwd_rs1_hit = 1, fwd_rs2_hit = 0.
REQ-040 SHALL cover: rst asserted during a grant cycle -> no write_reg next cycle, counter 0; conflict counter forced near max -> holds at 0xFFFF.
